dmem_arbiter: RTL and testbench

- Two-requester arbiter that shares the single-port 32-bit data memory between requester 0 (CPU load/store stage) and requester 1 (debug/DMA loader).
- Sits directly in front of the data memory:
  - Drives the memory's addr, data_in and write_enable.
  - Consumes the memory's combinational data_out.
  - Returns registered read responses to the winning requester.
- Provides round-robin fairness, optional locked bursts bounded by a hold limit, and out-of-range write suppression.

---
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port 32-bit data memory.
// Latency: grant and memory drive are combinational; the response is registered one cycle after accept.
// Backpressure: ready is a combinational grant, locked owners exclude the other side, and reset forces every ready low.
// Ports: clk/rst; r0_*/r1_* requester channels (valid/ready/we/lock/addr/wdata and
//        rsp_valid/rsp_data/rsp_err); mem_addr/mem_wdata/mem_we/mem_rdata memory side; busy.
module dmem_arbiter #(
  parameter int DEPTH    = 1024,
  parameter int LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic        r0_we,
  input  logic        r0_lock,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_rsp_valid,
  output logic [31:0] r0_rsp_data,
  output logic        r0_rsp_err,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic        r1_we,
  input  logic        r1_lock,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_rsp_valid,
  output logic [31:0] r1_rsp_data,
  output logic        r1_rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  // hold_cnt only ever reaches LOCK_MAX-1
  localparam int HW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  state_t        state, state_nx;
  logic          last, last_nx;        // 1: requester 1 was served last
  logic [HW-1:0] hold_cnt, hold_nx;

  logic          grant0, grant1, grant;
  logic          sel_we, sel_lock, sel_oor;
  logic [31:0]   sel_addr, sel_wdata;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      last     <= last_nx;
      hold_cnt <= hold_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    last_nx  = last;
    hold_nx  = hold_cnt;
    if (grant) begin
      // LOCK_MAX-1 is the last count that still allows another locked transfer
      if (sel_lock && (hold_cnt < HW'(LOCK_MAX - 1))) begin
        state_nx = grant0 ? OWN0 : OWN1;
        hold_nx  = hold_cnt + HW'(1);
      end else begin
        state_nx = IDLE;
        hold_nx  = '0;
        last_nx  = grant1;
      end
    end else if (state == OWN0) begin
      // owner went idle: release, costing one bubble cycle
      state_nx = IDLE;
      hold_nx  = '0;
      last_nx  = 1'b0;
    end else if (state == OWN1) begin
      state_nx = IDLE;
      hold_nx  = '0;
      last_nx  = 1'b1;
    end
  end

  // Output logic: grant selection and memory drive
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          grant0 = r0_valid & (~r1_valid | last);
          grant1 = r1_valid & (~r0_valid | ~last);
        end
        OWN0:    grant0 = r0_valid;
        OWN1:    grant1 = r1_valid;
        default: ;
      endcase
    end
    grant     = grant0 | grant1;
    sel_addr  = 32'd0;
    sel_wdata = 32'd0;
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    if (grant0) begin
      sel_addr  = r0_addr;
      sel_wdata = r0_wdata;
      sel_we    = r0_we;
      sel_lock  = r0_lock;
    end else if (grant1) begin
      sel_addr  = r1_addr;
      sel_wdata = r1_wdata;
      sel_we    = r1_we;
      sel_lock  = r1_lock;
    end
    // full 32-bit compare: addresses past DEPTH never alias onto low words
    sel_oor   = sel_addr >= 32'(DEPTH);
    mem_addr  = sel_addr;
    mem_wdata = sel_wdata;
    mem_we    = grant & sel_we & ~sel_oor;
    r0_ready  = grant0;
    r1_ready  = grant1;
    busy      = state != IDLE;
  end

  // Registered responses, one cycle after accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_rsp_valid <= 1'b0;
      r0_rsp_err   <= 1'b0;
      r0_rsp_data  <= 32'd0;
      r1_rsp_valid <= 1'b0;
      r1_rsp_err   <= 1'b0;
      r1_rsp_data  <= 32'd0;
    end else begin
      r0_rsp_valid <= grant0;
      r0_rsp_err   <= grant0 & sel_oor;
      r0_rsp_data  <= (grant0 & ~sel_we & ~sel_oor) ? mem_rdata : 32'd0;
      r1_rsp_valid <= grant1;
      r1_rsp_err   <= grant1 & sel_oor;
      r1_rsp_data  <= (grant1 & ~sel_we & ~sel_oor) ? mem_rdata : 32'd0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int DEPTH = 1024;

  logic        clk, rst;
  logic        r0_valid, r0_ready, r0_we, r0_lock;
  logic [31:0] r0_addr, r0_wdata, r0_rsp_data;
  logic        r0_rsp_valid, r0_rsp_err;
  logic        r1_valid, r1_ready, r1_we, r1_lock;
  logic [31:0] r1_addr, r1_wdata, r1_rsp_data;
  logic        r1_rsp_valid, r1_rsp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, busy;

  int errors = 0;
  int checks = 0;

  logic [32:0] q0[$];
  logic [32:0] q1[$];

  logic [31:0] mem    [DEPTH];
  logic [31:0] shadow [DEPTH];

  dmem_arbiter #(.DEPTH(DEPTH), .LOCK_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_lock(r0_lock),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rsp_valid(r0_rsp_valid),
    .r0_rsp_data(r0_rsp_data), .r0_rsp_err(r0_rsp_err),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_lock(r1_lock),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rsp_valid(r1_rsp_valid),
    .r1_rsp_data(r1_rsp_data), .r1_rsp_err(r1_rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: combinational read, write on rising edge
  assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr[9:0]] : 32'd0;
  always @(posedge clk) if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops expected responses whenever a pulse appears
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst) begin
      chk(32'(r0_ready & r1_ready), 32'd0, "ready_exclusive");
      if (r0_rsp_valid) begin
        if (q0.size() == 0) chk(32'd1, 32'd0, "r0_rsp_unexpected");
        else begin
          e = q0.pop_front();
          chk(r0_rsp_data, e[31:0], "r0_rsp_data");
          chk(32'(r0_rsp_err), 32'(e[32]), "r0_rsp_err");
        end
      end
      if (r1_rsp_valid) begin
        if (q1.size() == 0) chk(32'd1, 32'd0, "r1_rsp_unexpected");
        else begin
          e = q1.pop_front();
          chk(r1_rsp_data, e[31:0], "r1_rsp_data");
          chk(32'(r1_rsp_err), 32'(e[32]), "r1_rsp_err");
        end
      end
    end
  end

  // One cycle of stimulus with hand-specified expected grant and busy
  task automatic step(input logic v0, input logic we0, input logic lk0,
                      input logic [31:0] a0, input logic [31:0] d0,
                      input logic v1, input logic we1, input logic lk1,
                      input logic [31:0] a1, input logic [31:0] d1,
                      input logic eg0, input logic eg1, input logic ebusy,
                      input string nm);
    logic [31:0] ea, ed;
    logic        ewr, eoor;
    @(negedge clk);
    r0_valid = v0; r0_we = we0; r0_lock = lk0; r0_addr = a0; r0_wdata = d0;
    r1_valid = v1; r1_we = we1; r1_lock = lk1; r1_addr = a1; r1_wdata = d1;
    #1;
    ea   = eg0 ? a0 : (eg1 ? a1 : 32'd0);
    ed   = eg0 ? d0 : (eg1 ? d1 : 32'd0);
    ewr  = eg0 ? we0 : (eg1 ? we1 : 1'b0);
    eoor = ea >= DEPTH;
    chk(32'(r0_ready), 32'(eg0), {nm, " r0_ready"});
    chk(32'(r1_ready), 32'(eg1), {nm, " r1_ready"});
    chk(32'(busy), 32'(ebusy), {nm, " busy"});
    chk(mem_addr, ea, {nm, " mem_addr"});
    chk(32'(mem_we), 32'((eg0 | eg1) & ewr & ~eoor), {nm, " mem_we"});
    if (eg0 | eg1) begin
      logic [32:0] rsp;
      rsp = {eoor, (ewr || eoor) ? 32'd0 : shadow[ea[9:0]]};
      if (eg0) q0.push_back(rsp);
      else     q1.push_back(rsp);
      if (ewr && !eoor) shadow[ea[9:0]] = ed;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]    = 32'(i) ^ 32'hA5A5_0000;
      shadow[i] = 32'(i) ^ 32'hA5A5_0000;
    end
    rst = 1'b1;
    r0_valid = 0; r0_we = 0; r0_lock = 0; r0_addr = 0; r0_wdata = 0;
    r1_valid = 0; r1_we = 0; r1_lock = 0; r1_addr = 0; r1_wdata = 0;
    #3;
    chk(32'(r0_rsp_valid | r1_rsp_valid | r0_rsp_err | r1_rsp_err), 32'd0, "reset_rsp_flags");
    chk(r0_rsp_data | r1_rsp_data, 32'd0, "reset_rsp_data");
    chk(mem_addr | mem_wdata | 32'(mem_we) | 32'(busy), 32'd0, "reset_mem_busy");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // write then read back
    step(1,1,0,32'd5,32'hDEADBEEF, 0,0,0,0,0, 1,0,0, "wr5");
    step(1,0,0,32'd5,0,            0,0,0,0,0, 1,0,0, "rd5");
    // r1 alone so r0 wins the next tie
    step(0,0,0,0,0, 1,1,0,32'd7,32'h1111_1111, 0,1,0, "r1wr7");
    // strict alternation with both valid
    for (int k = 0; k < 3; k++) begin
      step(1,1,0,32'(40+k),32'(32'hA0+k), 1,0,0,32'd7,0, 1,0,0, "alt_r0");
      step(1,1,0,32'(40+k),32'(32'hA0+k), 1,0,0,32'(41+k),0, 0,1,0, "alt_r1");
    end
    // r0 alone so r1 wins the following tie
    step(1,1,0,32'd0,32'hCAFEF00D, 0,0,0,0,0, 1,0,0, "wr0");
    // r1 locked: 8 grants, then r0
    for (int k = 0; k < 8; k++)
      step(1,0,0,32'd2,0, 1,0,1,32'(100+k),0, 0,1,(k > 0), "lock_r1");
    step(1,0,0,32'd2,0, 1,0,1,32'd108,0, 1,0,0, "lock_release");
    // out-of-range write suppressed, prior data intact
    step(1,1,0,32'd1024,32'h12345678, 0,0,0,0,0, 1,0,0, "oor_wr");
    step(1,0,0,32'd0,0,               0,0,0,0,0, 1,0,0, "rd0_after_oor");
    step(0,0,0,0,0, 1,0,0,32'h0001_0005,0, 0,1,0, "oor_rd_nowrap");
    // r0 locked for two transfers then drops valid
    step(1,0,1,32'd5,0, 1,0,0,32'd20,0, 1,0,0, "lk0_a");
    step(1,0,1,32'd6,0, 1,0,0,32'd20,0, 1,0,1, "lk0_b");
    step(0,0,0,0,0,     1,0,0,32'd20,0, 0,0,1, "bubble");
    step(0,0,0,0,0,     1,0,0,32'd20,0, 0,1,0, "r1_after_bubble");

    // reset during an r1 read accept: no response may appear
    @(negedge clk);
    r0_valid = 0; r1_valid = 1; r1_we = 0; r1_lock = 0; r1_addr = 32'd30;
    #1;
    chk(32'(r1_ready), 32'd1, "pre_reset r1_ready");
    #2 rst = 1'b1;
    #1;
    chk(32'(r1_ready | r0_ready | mem_we | busy), 32'd0, "in_reset ctl");
    chk(mem_addr | mem_wdata, 32'd0, "in_reset mem");
    @(posedge clk); #1;
    chk(32'(r1_rsp_valid | r0_rsp_valid | r1_rsp_err), 32'd0, "in_reset rsp");
    chk(r1_rsp_data, 32'd0, "in_reset rsp_data");
    @(negedge clk);
    rst = 1'b0;
    r1_valid = 0;
    step(1,0,0,32'd3,0, 1,0,0,32'd4,0, 1,0,0, "tie_after_reset");
    step(0,0,0,0,0, 0,0,0,0,0, 0,0,0, "idle1");
    step(0,0,0,0,0, 0,0,0,0,0, 0,0,0, "idle2");
    @(negedge clk);
    chk(32'(q0.size()), 32'd0, "r0_missing_rsp");
    chk(32'(q1.size()), 32'd0, "r1_missing_rsp");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
